interpolate: RTL and testbench

INTERPOLATE -- requirements
Module: interpolate

---
 rtl/interpolate.sv | 124 ++++++++++++
 tb/tb_interpolate.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/interpolate.sv
// Sample-rate interpolator by R with a 1-deep pending buffer and sticky ovf/unf flags.
// Build option: INTERP_HOLD_EN selects zero-order hold fill (default build fills with zeros).
module interpolate #(
  parameter int W = 37,
  parameter int R = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] din,
  input  logic                din_vld,
  output logic                din_rdy,
  input  logic                flag_clr,
  output logic signed [W-1:0] dout,
  output logic                dout_vld,
  output logic [3:0]          phase,
  output logic                ovf,
  output logic                unf
);

  localparam logic [3:0] PH_LAST = 4'(R - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              r_state, w_state_nxt;
  logic signed [W-1:0] r_dout, w_dout_nxt;
  logic signed [W-1:0] r_pend, w_pend_nxt;
  logic signed [W-1:0] w_fill;
  logic                r_pend_v, w_pend_v_nxt;
  logic                r_vld, w_vld_nxt;
  logic [3:0]          r_phase, w_phase_nxt;
  logic                r_ovf, r_unf;
  logic                w_ovf_set, w_unf_set;
  logic                w_last;

  assign w_last  = (r_phase == PH_LAST);
  assign din_rdy = !r_pend_v || ((r_state == RUN) && w_last);

  // On fill phases dout still carries the phase-0 sample, so hold just keeps it.
`ifdef INTERP_HOLD_EN
  assign w_fill = r_dout;
`else
  assign w_fill = '0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_dout_nxt   = r_dout;
    w_pend_nxt   = r_pend;
    w_pend_v_nxt = r_pend_v;
    w_phase_nxt  = r_phase;
    w_vld_nxt    = 1'b0;
    w_ovf_set    = 1'b0;
    w_unf_set    = 1'b0;
    case (r_state)
      IDLE: begin
        if (din_vld) begin
          w_state_nxt = RUN;
          w_dout_nxt  = din;
          w_phase_nxt = 4'd0;
          w_vld_nxt   = 1'b1;
        end
      end
      RUN: begin
        if (!w_last) begin
          w_phase_nxt = r_phase + 4'd1;
          w_dout_nxt  = w_fill;
          w_vld_nxt   = 1'b1;
          if (din_vld) begin
            if (!r_pend_v) begin
              w_pend_nxt   = din;
              w_pend_v_nxt = 1'b1;
            end else begin
              w_ovf_set = 1'b1;
            end
          end
        end else if (r_pend_v) begin
          w_dout_nxt   = r_pend;
          w_phase_nxt  = 4'd0;
          w_vld_nxt    = 1'b1;
          w_pend_v_nxt = din_vld;
          if (din_vld) w_pend_nxt = din;
        end else if (din_vld) begin
          w_dout_nxt  = din;
          w_phase_nxt = 4'd0;
          w_vld_nxt   = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_unf_set   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Set events take precedence over a simultaneous flag clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_dout   <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_vld    <= 1'b0;
      r_phase  <= 4'd0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dout   <= w_dout_nxt;
      r_pend   <= w_pend_nxt;
      r_pend_v <= w_pend_v_nxt;
      r_vld    <= w_vld_nxt;
      r_phase  <= w_phase_nxt;
      r_ovf    <= w_ovf_set | (r_ovf & ~flag_clr);
      r_unf    <= w_unf_set | (r_unf & ~flag_clr);
    end
  end

  assign dout     = r_dout;
  assign dout_vld = r_vld;
  assign phase    = r_phase;
  assign ovf      = r_ovf;
  assign unf      = r_unf;

endmodule

// File: tb/tb_interpolate.sv
// Bench for interpolate: directed scenarios then random traffic, checked cycle by cycle
// against a frame/queue-level reference model.
module tb_interpolate;

  localparam int W = 37;
  localparam int R = 5;
`ifdef INTERP_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic signed [W-1:0] din;
  logic                din_vld;
  logic                din_rdy;
  logic                flag_clr;
  logic signed [W-1:0] dout;
  logic                dout_vld;
  logic [3:0]          phase;
  logic                ovf;
  logic                unf;

  interpolate #(.W(W), .R(R)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_vld  (din_vld),
    .din_rdy  (din_rdy),
    .flag_clr (flag_clr),
    .dout     (dout),
    .dout_vld (dout_vld),
    .phase    (phase),
    .ovf      (ovf),
    .unf      (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a stream of frames, each R outputs long, fed from a queue of waiting samples.
  bit                  m_known = 1'b0;
  bit                  m_run;
  int                  m_ph;
  logic signed [W-1:0] m_s0;
  logic signed [W-1:0] m_dout;
  logic signed [W-1:0] m_wait[$];
  bit                  m_vld;
  bit                  m_ovf;
  bit                  m_unf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic signed [W-1:0] s);
    m_s0   = s;
    m_dout = s;
    m_ph   = 0;
    m_vld  = 1'b1;
    m_run  = 1'b1;
  endtask

  task automatic model_step(input bit v, input logic signed [W-1:0] d, input bit c, input bit r);
    bit ovf_ev;
    bit unf_ev;
    ovf_ev = 1'b0;
    unf_ev = 1'b0;
    if (r) begin
      m_known = 1'b1;
      m_run   = 1'b0;
      m_ph    = 0;
      m_s0    = '0;
      m_dout  = '0;
      m_vld   = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_wait.delete();
      return;
    end
    if (!m_run) begin
      if (v) start_frame(d);
      else m_vld = 1'b0;
    end else if (m_ph < R - 1) begin
      m_ph++;
      m_dout = HOLD ? m_s0 : '0;
      m_vld  = 1'b1;
      if (v) begin
        if (m_wait.size() == 0) m_wait.push_back(d);
        else ovf_ev = 1'b1;
      end
    end else begin
      if (m_wait.size() > 0) begin
        start_frame(m_wait.pop_front());
        if (v) m_wait.push_back(d);
      end else if (v) begin
        start_frame(d);
      end else begin
        m_run  = 1'b0;
        m_vld  = 1'b0;
        unf_ev = 1'b1;
      end
    end
    m_ovf = ovf_ev || (m_ovf && !c);
    m_unf = unf_ev || (m_unf && !c);
  endtask

  task automatic cyc(input bit v, input logic signed [W-1:0] d, input bit c = 1'b0, input bit r = 1'b0);
    din_vld  = v;
    din      = d;
    flag_clr = c;
    rst      = r;
    #1;
    if (m_known && !r)
      chk("din_rdy", din_rdy, (m_wait.size() == 0) || (m_run && m_ph == R - 1));
    @(posedge clk);
    model_step(v, d, c, r);
    #1;
    chk("dout", dout, m_dout);
    chk("dout_vld", dout_vld, m_vld);
    if (m_vld) chk("phase", phase, 4'(m_ph));
    chk("ovf", ovf, m_ovf);
    chk("unf", unf, m_unf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0);
  endtask

  initial begin
    logic [63:0]         rr;
    logic signed [W-1:0] rd;
    bit                  rv, rc, rx;

    din = '0; din_vld = 1'b0; flag_clr = 1'b0; rst = 1'b1;

    // Reset state
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, 37'sd5, 1'b0, 1'b1);
    chk("rst_dout", dout, 0);
    chk("rst_phase", phase, 0);
    idle(2);

    // Single sample then underrun
    cyc(1'b1, 37'sd100);
    chk("single_dout", dout, 100);
    chk("single_phase", phase, 0);
    idle(4);
    chk("single_fill", dout, HOLD ? 100 : 0);
    idle(1);
    chk("single_unf", unf, 1);
    chk("single_vld", dout_vld, 0);
    idle(2);

    // Steady stream 1,-2,3 every R cycles
    cyc(1'b1, 37'sd1); idle(R - 1);
    cyc(1'b1, -37'sd2);
    chk("stream_dout", dout, -2);
    idle(R - 1);
    cyc(1'b1, 37'sd3);
    chk("stream_dout3", dout, 3);
    chk("stream_ovf", ovf, 0);
    idle(R + 1);

    // Bypass at the last phase
    cyc(1'b1, 37'sd5); idle(R - 1);
    chk("byp_phase_pre", phase, R - 1);
    cyc(1'b1, -37'sd7);
    chk("byp_dout", dout, -7);
    chk("byp_phase", phase, 0);
    chk("byp_vld", dout_vld, 1);

    // Overflow: buffer at phase 1, drop at phase 2
    idle(1);
    cyc(1'b1, 37'sd11);
    chk("ovf_rdy", din_rdy, 0);
    cyc(1'b1, 37'sd22);
    chk("ovf_set", ovf, 1);
    idle(2);
    chk("ovf_buffered", dout, 11);
    chk("ovf_buf_phase", phase, 0);
    idle(R);

    // Flag clear, then clear colliding with underrun
    cyc(1'b0, '0, 1'b1);
    chk("clr_ovf", ovf, 0);
    chk("clr_unf", unf, 0);
    cyc(1'b1, 37'sd1); idle(R - 1);
    cyc(1'b0, '0, 1'b1);
    chk("clr_vs_unf", unf, 1);
    idle(1);

    // Reset mid-RUN with a pending sample and a coincident din_vld
    cyc(1'b1, 37'sd3); idle(1);
    cyc(1'b1, 37'sd4);
    cyc(1'b1, 37'sd55, 1'b0, 1'b1);
    chk("midrst_dout", dout, 0);
    chk("midrst_vld", dout_vld, 0);
    idle(3);
    cyc(1'b1, 37'sd9);
    chk("restart_dout", dout, 9);
    chk("restart_phase", phase, 0);
    idle(R + 1);

    // Extreme values pass bit-exact
    rd = {1'b0, {(W-1){1'b1}}};
    cyc(1'b1, rd); idle(R - 1);
    rd = {1'b1, {(W-1){1'b0}}};
    cyc(1'b1, rd);
    idle(R + 2);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rr = {$urandom, $urandom};
      rd = rr[W-1:0];
      rv = ($urandom_range(0, 99) < 35);
      rc = ($urandom_range(0, 99) < 5);
      rx = ($urandom_range(0, 999) < 8);
      cyc(rv, rd, rc, rx);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
